// File: rtl/systolic_pkg.sv
// Shared constants, FSM state type and index helpers for the systolic result drain.
package systolic_pkg;
   localparam int N          = 3;
   localparam int DW         = 64;
   localparam int KW         = 16;
   localparam int MAC_LAT    = 1;
   // Far-corner MAC sees its last operand 2*(N-1) cycles late, then needs MAC_LAT more.
   localparam int SETTLE_LAT = 2 * (N - 1) + MAC_LAT;
   localparam int NN         = N * N;
   localparam int IW         = $clog2(NN);
   localparam int SW         = $clog2(SETTLE_LAT + 1);

   typedef enum logic [2:0] {
      IDLE,
      FEED,
      SETTLE,
      CAPTURE,
      DRAIN,
      DONE
   } state_e;

   function automatic logic [1:0] row_of(input logic [IW-1:0] idx);
      logic [IW-1:0] r;
      r = idx / IW'(N);
      return r[1:0];
   endfunction

   function automatic logic [1:0] col_of(input logic [IW-1:0] idx);
      logic [IW-1:0] c;
      c = idx % IW'(N);
      return c[1:0];
   endfunction
endpackage

// File: rtl/systolic_result_bank.sv
// Snapshot of all N*N accumulators, loaded in one cycle and read back by flat index.
module systolic_result_bank
   import systolic_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [NN*DW-1:0] acc_i,
   input  logic [IW-1:0]    idx_i,
   output logic [DW-1:0]    rdata_o
);

   logic [DW-1:0] bank_q [NN];
   logic [DW-1:0] bank_d [NN];

   always_comb begin
      for (int i = 0; i < NN; i++) begin
         bank_d[i] = load_i ? acc_i[i*DW +: DW] : bank_q[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NN; i++) begin
            bank_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NN; i++) begin
            bank_q[i] <= bank_d[i];
         end
      end
   end

   // Explicit compare mux keeps unused index codes (NN..2^IW-1) reading zero.
   always_comb begin
      rdata_o = '0;
      for (int i = 0; i < NN; i++) begin
         if (idx_i == IW'(i)) begin
            rdata_o = bank_q[i];
         end
      end
   end

endmodule

// File: rtl/systolic_result_drain.sv
// Sequences one matrix product: feed K beats, settle, snapshot accumulators, clear MACs, drain row-major.
// out_valid/out_ready: a beat transfers when both are high; while valid and not ready the beat holds stable.
module systolic_result_drain
   import systolic_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [KW-1:0]    k_len,
   input  logic [NN*DW-1:0] acc_in,
   output logic             feed_en,
   output logic             mac_clr,
   output logic [DW-1:0]    out_data,
   output logic [1:0]       out_row,
   output logic [1:0]       out_col,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             busy,
   output logic             done,
   output state_e           dbg_state
);

   state_e         state_q, state_d;
   logic [KW-1:0]  beat_cnt_q, beat_cnt_d;
   logic [SW-1:0]  settle_cnt_q, settle_cnt_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic           first_q, first_d;
   logic           zero_k_q, zero_k_d;
   logic [DW-1:0]  bank_rdata;
   logic           bank_load;

   assign bank_load = (state_q == CAPTURE);

   systolic_result_bank u_bank (
      .clk     (clk),
      .rst     (rst),
      .load_i  (bank_load),
      .acc_i   (acc_in),
      .idx_i   (idx_q),
      .rdata_o (bank_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         beat_cnt_q   <= '0;
         settle_cnt_q <= '0;
         idx_q        <= '0;
         first_q      <= 1'b0;
         zero_k_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         beat_cnt_q   <= beat_cnt_d;
         settle_cnt_q <= settle_cnt_d;
         idx_q        <= idx_d;
         first_q      <= first_d;
         zero_k_q     <= zero_k_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      beat_cnt_d   = beat_cnt_q;
      settle_cnt_d = settle_cnt_q;
      idx_d        = idx_q;
      first_d      = 1'b0;
      zero_k_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (k_len == '0) begin
                  state_d  = DONE;
                  zero_k_d = 1'b1;
               end else begin
                  state_d    = FEED;
                  beat_cnt_d = k_len;
               end
            end
         end
         FEED: begin
            beat_cnt_d = beat_cnt_q - KW'(1);
            if (beat_cnt_q == KW'(1)) begin
               state_d      = SETTLE;
               settle_cnt_d = '0;
            end
         end
         SETTLE: begin
            if (settle_cnt_q == SW'(SETTLE_LAT - 1)) begin
               state_d      = CAPTURE;
               settle_cnt_d = '0;
            end else begin
               settle_cnt_d = settle_cnt_q + SW'(1);
            end
         end
         CAPTURE: begin
            state_d = DRAIN;
            idx_d   = '0;
            first_d = 1'b1;
         end
         DRAIN: begin
            if (out_ready) begin
               if (idx_q == IW'(NN - 1)) begin
                  state_d = DONE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // The clear normally follows the snapshot; a zero-length product clears in its DONE cycle.
   always_comb begin
      feed_en   = (state_q == FEED);
      out_valid = (state_q == DRAIN);
      mac_clr   = ((state_q == DRAIN) && first_q) || ((state_q == DONE) && zero_k_q);
      out_last  = out_valid && (idx_q == IW'(NN - 1));
      out_data  = out_valid ? bank_rdata : '0;
      out_row   = out_valid ? row_of(idx_q) : 2'd0;
      out_col   = out_valid ? col_of(idx_q) : 2'd0;
      busy      = (state_q != IDLE);
      done      = (state_q == DONE);
      dbg_state = state_q;
   end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Cycle-trace bench for systolic_result_drain: records one product per run, each test checks its trace.
module tb_systolic_result_drain;
   import systolic_pkg::*;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [KW-1:0]    k_len;
   logic [NN*DW-1:0] acc_in;
   logic             feed_en, mac_clr, out_valid, out_ready, out_last, busy, done;
   logic [DW-1:0]    out_data;
   logic [1:0]       out_row, out_col;
   state_e           dbg_state;

   always #5 clk = ~clk;

   systolic_result_drain dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .k_len     (k_len),
      .acc_in    (acc_in),
      .feed_en   (feed_en),
      .mac_clr   (mac_clr),
      .out_data  (out_data),
      .out_row   (out_row),
      .out_col   (out_col),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done),
      .dbg_state (dbg_state)
   );

   typedef struct {
      logic          feed, clr, valid, ready, last, busy, done;
      logic [DW-1:0] data;
      logic [1:0]    row, col;
   } smp_t;

   localparam int MAXT = 200;
   smp_t          tr[MAXT];
   smp_t          post_rst;
   int            tlen, t_done;
   logic [DW-1:0] acc_words[NN];
   logic [DW-1:0] exp_q[$];
   int            n_checks = 0;
   int            n_fail = 0;
   int n_feed, f_first, f_last, n_clr, clr_t, n_done, n_busy, n_valid, v_first, n_xfer, last_xfer_t, n_last;

   function automatic smp_t take();
      smp_t s;
      s.feed = feed_en; s.clr = mac_clr; s.valid = out_valid; s.ready = out_ready;
      s.last = out_last; s.busy = busy; s.done = done;
      s.data = out_data; s.row = out_row; s.col = out_col;
      return s;
   endfunction

   task automatic load_acc();
      for (int i = 0; i < NN; i++) acc_in[i*DW +: DW] = acc_words[i];
   endtask

   // Drives one product from IDLE and records every cycle; t=0 is the start cycle.
   task automatic run_product(input int k, input int rmode, input bit poke, input bit corrupt,
                              input int abort_at);
      int xfers;
      exp_q.delete();
      for (int i = 0; i < NN; i++) exp_q.push_back(acc_words[i]);
      load_acc();
      k_len = KW'(k);
      start = 1'b1;
      xfers = 0; t_done = -1; tlen = 0;
      for (int t = 0; t < MAXT; t++) begin
         if (t > 0) start = 1'b0;
         if (poke && (t == 2 || t == k + SETTLE_LAT + 3)) begin start = 1'b1; k_len = KW'(7); end
         if (corrupt && t == k + SETTLE_LAT + 2) acc_in = '1;
         case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((t % 4) == 0) || ((t % 4) == 3);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         if (abort_at >= 0 && xfers == abort_at) begin
            rst = 1'b1;
            #1;
            post_rst = take();
            @(posedge clk); #1;
            rst = 1'b0; start = 1'b0; out_ready = 1'b0;
            tlen = t;
            return;
         end
         #1;
         tr[t] = take();
         if (tr[t].valid && tr[t].ready) xfers++;
         if (tr[t].done && t_done < 0) t_done = t;
         tlen = t + 1;
         @(posedge clk); #1;
         if (t_done >= 0 && t >= t_done + 1) break;
      end
      start = 1'b0;
      out_ready = 1'b0;
   endtask

   task automatic stats();
      n_feed = 0; f_first = -1; f_last = -1; n_clr = 0; clr_t = -1; n_done = 0; n_busy = 0;
      n_valid = 0; v_first = -1; n_xfer = 0; last_xfer_t = -1; n_last = 0;
      for (int t = 0; t < tlen; t++) begin
         if (tr[t].feed) begin n_feed++; if (f_first < 0) f_first = t; f_last = t; end
         if (tr[t].clr) begin n_clr++; if (clr_t < 0) clr_t = t; end
         if (tr[t].done) n_done++;
         if (tr[t].busy) n_busy++;
         if (tr[t].valid) begin n_valid++; if (v_first < 0) v_first = t; end
         if (tr[t].valid && tr[t].ready) begin n_xfer++; last_xfer_t = t; end
         if (tr[t].last) n_last++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; k_len = '0; out_ready = 1'b0; acc_in = '0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({feed_en, mac_clr, out_valid, out_last, busy, done} !== 6'b0) begin
         n_fail++; $display("FAIL reset_ctrl: got %b expected 000000", {feed_en, mac_clr, out_valid, out_last, busy, done});
      end
      n_checks++;
      if (out_data !== '0 || out_row !== 2'd0 || out_col !== 2'd0) begin
         n_fail++; $display("FAIL reset_data: got data=%h row=%0d col=%0d expected 0", out_data, out_row, out_col);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int i;
      logic [DW-1:0] w;
      for (int j = 0; j < NN; j++) acc_words[j] = DW'(j + 1);
      run_product(2, 0, 1'b0, 1'b0, -1);
      stats();
      n_checks++;
      if (n_feed != 2 || f_first != 1 || f_last != 2) begin
         n_fail++; $display("FAIL basic_feed: got count=%0d first=%0d last=%0d expected 2,1,2", n_feed, f_first, f_last);
      end
      n_checks++;
      if (v_first != 2 + SETTLE_LAT + 2) begin
         n_fail++; $display("FAIL basic_first_valid: got t=%0d expected %0d", v_first, 2 + SETTLE_LAT + 2);
      end
      n_checks++;
      if (n_xfer != NN) begin n_fail++; $display("FAIL basic_xfers: got %0d expected %0d", n_xfer, NN); end
      i = 0;
      for (int t = 0; t < tlen; t++) if (tr[t].valid && tr[t].ready) begin
         w = exp_q.pop_front();
         n_checks++;
         if (tr[t].data !== w || tr[t].row !== 2'(i / N) || tr[t].col !== 2'(i % N) || tr[t].last !== (i == NN - 1)) begin
            n_fail++;
            $display("FAIL basic_beat%0d: got data=%h r%0d c%0d last=%b expected data=%h r%0d c%0d last=%b",
                     i, tr[t].data, tr[t].row, tr[t].col, tr[t].last, w, i / N, i % N, i == NN - 1);
         end
         i++;
      end
      n_checks++;
      if (n_last != 1) begin n_fail++; $display("FAIL basic_last_count: got %0d expected 1", n_last); end
      n_checks++;
      if (n_done != 1 || t_done != last_xfer_t + 1) begin
         n_fail++; $display("FAIL basic_done: got count=%0d t=%0d expected 1 at t=%0d", n_done, t_done, last_xfer_t + 1);
      end
      n_checks++;
      if (tr[0].busy !== 1'b0 || tr[1].busy !== 1'b1 || tr[t_done + 1].busy !== 1'b0) begin
         n_fail++; $display("FAIL basic_busy: got %b%b%b expected 010", tr[0].busy, tr[1].busy, tr[t_done + 1].busy);
      end
   endtask

   task automatic test_stall();
      int i;
      logic [DW-1:0] w;
      for (int j = 0; j < NN; j++) acc_words[j] = {$urandom, $urandom};
      run_product(4, 1, 1'b0, 1'b0, -1);
      stats();
      for (int t = 0; t + 1 < tlen; t++) if (tr[t].valid && !tr[t].ready) begin
         n_checks++;
         if (tr[t + 1].valid !== 1'b1 || tr[t + 1].data !== tr[t].data || tr[t + 1].row !== tr[t].row ||
             tr[t + 1].col !== tr[t].col || tr[t + 1].last !== tr[t].last) begin
            n_fail++; $display("FAIL stall_hold_t%0d: got v=%b data=%h expected v=1 data=%h", t + 1, tr[t + 1].valid, tr[t + 1].data, tr[t].data);
         end
      end
      n_checks++;
      if (n_xfer != NN) begin n_fail++; $display("FAIL stall_xfers: got %0d expected %0d", n_xfer, NN); end
      i = 0;
      for (int t = 0; t < tlen; t++) if (tr[t].valid && tr[t].ready) begin
         w = exp_q.pop_front();
         n_checks++;
         if (tr[t].data !== w || tr[t].row !== 2'(i / N) || tr[t].col !== 2'(i % N)) begin
            n_fail++; $display("FAIL stall_beat%0d: got data=%h r%0d c%0d expected data=%h r%0d c%0d",
                               i, tr[t].data, tr[t].row, tr[t].col, w, i / N, i % N);
         end
         i++;
      end
   endtask

   task automatic test_start_ignored();
      for (int j = 0; j < NN; j++) acc_words[j] = {$urandom, $urandom};
      run_product(3, 0, 1'b1, 1'b0, -1);
      stats();
      n_checks++;
      if (n_feed != 3 || f_first != 1) begin
         n_fail++; $display("FAIL ignore_feed: got count=%0d first=%0d expected 3,1", n_feed, f_first);
      end
      n_checks++;
      if (n_done != 1 || n_xfer != NN) begin
         n_fail++; $display("FAIL ignore_done: got done=%0d xfers=%0d expected 1,%0d", n_done, n_xfer, NN);
      end
      n_checks++;
      if (tr[tlen - 1].busy !== 1'b0) begin n_fail++; $display("FAIL ignore_idle: got busy=%b expected 0", tr[tlen - 1].busy); end
   endtask

   task automatic test_zero_k();
      run_product(0, 0, 1'b0, 1'b0, -1);
      stats();
      n_checks++;
      if (n_feed != 0 || n_valid != 0) begin
         n_fail++; $display("FAIL zero_k_activity: got feed=%0d valid=%0d expected 0,0", n_feed, n_valid);
      end
      n_checks++;
      if (tr[1].clr !== 1'b1 || tr[1].done !== 1'b1 || n_clr != 1 || n_done != 1) begin
         n_fail++; $display("FAIL zero_k_pulses: got clr=%b done=%b counts %0d,%0d expected 1,1,1,1", tr[1].clr, tr[1].done, n_clr, n_done);
      end
      n_checks++;
      if (n_busy != 1) begin n_fail++; $display("FAIL zero_k_busy: got %0d cycles expected 1", n_busy); end
   endtask

   task automatic test_reset_mid();
      int i;
      logic [DW-1:0] w;
      for (int j = 0; j < NN; j++) acc_words[j] = {$urandom, $urandom};
      run_product(2, 0, 1'b0, 1'b0, 4);
      n_checks++;
      if ({post_rst.feed, post_rst.clr, post_rst.valid, post_rst.last, post_rst.busy, post_rst.done} !== 6'b0 ||
          post_rst.data !== '0 || post_rst.row !== 2'd0 || post_rst.col !== 2'd0) begin
         n_fail++; $display("FAIL midrst_outputs: got v=%b busy=%b data=%h expected all 0", post_rst.valid, post_rst.busy, post_rst.data);
      end
      for (int j = 0; j < NN; j++) acc_words[j] = {$urandom, $urandom};
      run_product(3, 0, 1'b0, 1'b0, -1);
      stats();
      n_checks++;
      if (n_xfer != NN || n_done != 1 || n_clr != 1) begin
         n_fail++; $display("FAIL midrst_rerun: got xfers=%0d done=%0d clr=%0d expected %0d,1,1", n_xfer, n_done, n_clr, NN);
      end
      i = 0;
      for (int t = 0; t < tlen; t++) if (tr[t].valid && tr[t].ready) begin
         w = exp_q.pop_front();
         n_checks++;
         if (tr[t].data !== w || tr[t].row !== 2'(i / N) || tr[t].col !== 2'(i % N)) begin
            n_fail++; $display("FAIL midrst_beat%0d: got data=%h r%0d c%0d expected data=%h r%0d c%0d",
                               i, tr[t].data, tr[t].row, tr[t].col, w, i / N, i % N);
         end
         i++;
      end
   endtask

   task automatic test_isolation();
      int i;
      logic [DW-1:0] w;
      for (int j = 0; j < NN; j++) acc_words[j] = {$urandom, $urandom};
      run_product(3, 0, 1'b0, 1'b1, -1);
      stats();
      n_checks++;
      if (n_clr != 1 || clr_t != 3 + SETTLE_LAT + 2 || clr_t != v_first) begin
         n_fail++; $display("FAIL iso_clr: got count=%0d t=%0d expected 1 at t=%0d", n_clr, clr_t, 3 + SETTLE_LAT + 2);
      end
      i = 0;
      for (int t = 0; t < tlen; t++) if (tr[t].valid && tr[t].ready) begin
         w = exp_q.pop_front();
         n_checks++;
         if (tr[t].data !== w) begin
            n_fail++; $display("FAIL iso_beat%0d: got %h expected %h", i, tr[t].data, w);
         end
         i++;
      end
      n_checks++;
      if (i != NN) begin n_fail++; $display("FAIL iso_xfers: got %0d expected %0d", i, NN); end
   endtask

   task automatic test_random();
      int i, k;
      logic [DW-1:0] w;
      for (int it = 0; it < 5; it++) begin
         k = $urandom_range(1, 9);
         for (int j = 0; j < NN; j++) acc_words[j] = {$urandom, $urandom};
         run_product(k, 2, 1'b0, 1'b0, -1);
         stats();
         n_checks++;
         if (n_feed != k || v_first != k + SETTLE_LAT + 2 || n_done != 1 || n_xfer != NN) begin
            n_fail++; $display("FAIL rand%0d_timing: got feed=%0d first_valid=%0d done=%0d xfers=%0d expected %0d,%0d,1,%0d",
                               it, n_feed, v_first, n_done, n_xfer, k, k + SETTLE_LAT + 2, NN);
         end
         i = 0;
         for (int t = 0; t < tlen; t++) if (tr[t].valid && tr[t].ready) begin
            w = exp_q.pop_front();
            n_checks++;
            if (tr[t].data !== w || tr[t].row !== 2'(i / N) || tr[t].col !== 2'(i % N) || tr[t].last !== (i == NN - 1)) begin
               n_fail++; $display("FAIL rand%0d_beat%0d: got data=%h r%0d c%0d expected data=%h r%0d c%0d",
                                  it, i, tr[t].data, tr[t].row, tr[t].col, w, i / N, i % N);
            end
            i++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_start_ignored();
      test_zero_k();
      test_reset_mid();
      test_isolation();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
